// File: rtl/sha_ctrl_pkg.sv
// Shared definitions for the SHA-2 round controllers: FSM state encoding,
// round counts and the message-word window depth.
package sha_ctrl_pkg;

  localparam int NUM_ROUNDS_512 = 80;
  localparam int NUM_ROUNDS_256 = 64;
  localparam int MSG_WORDS      = 16;
  localparam int ROUND_IDX_W    = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/sha_round_cnt.sv
// Round index counter: advances on enable, wraps to zero after the last
// round and flags the terminal count so the FSM can leave ROUND.
module sha_round_cnt #(
  parameter int NUM_ROUNDS = 80,
  parameter int IDX_W      = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             tc_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] OneIdx  = IDX_W'(1);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign tc_o  = (idx_q == LastIdx);
  assign idx_o = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = tc_o ? '0 : idx_q + OneIdx;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sha512_round_ctrl.sv
// SHA-512 compression round controller. Define SHA_CTRL_ABORT_EN to add an
// abort input that drops an in-flight block back to IDLE without hashing.
module sha512_round_ctrl #(
  parameter int NUM_ROUNDS = sha_ctrl_pkg::NUM_ROUNDS_512,
  parameter int MSG_WORDS  = sha_ctrl_pkg::MSG_WORDS
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       first_blk,
  input  logic       msg_valid,
`ifdef SHA_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       msg_ready,
  output logic       busy,
  output logic       done,
  output logic       init_en,
  output logic       init_iv,
  output logic       round_en,
  output logic       w_sel,
  output logic       sched_en,
  output logic [6:0] round_idx,
  output logic       hash_upd_en
);

  import sha_ctrl_pkg::*;

  localparam logic [ROUND_IDX_W-1:0] MsgLimit = ROUND_IDX_W'(MSG_WORDS);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic        first_blk_q;
  logic        first_blk_d;
  logic        cnt_clr;
  logic        cnt_tc;
  logic        msg_phase;

  sha_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (ROUND_IDX_W)
  ) u_round_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (cnt_clr),
    .en_i  (round_en),
    .idx_o (round_idx),
    .tc_o  (cnt_tc)
  );

  // The first MSG_WORDS rounds consume external words; later ones use the schedule.
  assign msg_phase = (round_idx < MsgLimit);

  always_comb begin
    state_d     = state_q;
    first_blk_d = first_blk_q;
    busy        = (state_q != ST_IDLE);
    msg_ready   = 1'b0;
    done        = 1'b0;
    init_en     = 1'b0;
    init_iv     = 1'b0;
    round_en    = 1'b0;
    w_sel       = 1'b0;
    sched_en    = 1'b0;
    hash_upd_en = 1'b0;
    cnt_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          first_blk_d = first_blk;
          state_d     = ST_INIT;
        end
      end
      ST_INIT: begin
        init_en = 1'b1;
        init_iv = first_blk_q;
        cnt_clr = 1'b1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (msg_phase) begin
          msg_ready = msg_valid;
          round_en  = msg_valid;
          sched_en  = msg_valid;
        end else begin
          w_sel    = 1'b1;
          round_en = 1'b1;
          sched_en = 1'b1;
        end
        if (round_en && cnt_tc) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        hash_upd_en = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SHA_CTRL_ABORT_EN
    // An abort suppresses this cycle's enables so no partial update escapes.
    if (abort && (state_q inside {ST_INIT, ST_ROUND, ST_FINAL})) begin
      state_d     = ST_IDLE;
      cnt_clr     = 1'b1;
      msg_ready   = 1'b0;
      init_en     = 1'b0;
      init_iv     = 1'b0;
      round_en    = 1'b0;
      sched_en    = 1'b0;
      hash_upd_en = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      first_blk_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_blk_q <= first_blk_d;
    end
  end

endmodule

// File: tb/tb_sha512_round_ctrl.sv
// Directed bench for sha512_round_ctrl; covers the abort path when
// SHA_CTRL_ABORT_EN is defined.
module tb_sha512_round_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       first_blk;
  logic       msg_valid;
  logic       msg_ready;
  logic       busy;
  logic       done;
  logic       init_en;
  logic       init_iv;
  logic       round_en;
  logic       w_sel;
  logic       sched_en;
  logic [6:0] round_idx;
  logic       hash_upd_en;
`ifdef SHA_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [15:0] outs;
  int checks = 0;
  int errors = 0;

  assign outs = {msg_ready, busy, done, init_en, init_iv, round_en, w_sel,
                 sched_en, hash_upd_en, round_idx};

  sha512_round_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .first_blk   (first_blk),
    .msg_valid   (msg_valid),
`ifdef SHA_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .msg_ready   (msg_ready),
    .busy        (busy),
    .done        (done),
    .init_en     (init_en),
    .init_iv     (init_iv),
    .round_en    (round_en),
    .w_sel       (w_sel),
    .sched_en    (sched_en),
    .round_idx   (round_idx),
    .hash_upd_en (hash_upd_en)
  );

  always #5 CLK = ~CLK;

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Cycle 1 is the cycle in which start is presented; INIT is cycle 2, round t is cycle t+3.
  task automatic applyStimulus(input logic fb, input int stallAt, input int stallLen,
                               input bit toggle, input bit holdStart,
                               output int doneCyc, output int initCnt, output int ivCnt,
                               output int roundCnt, output int hashCnt, output int errCnt);
    int  expIdx;
    bit  inStall;
    expIdx   = 0;
    doneCyc  = -1;
    initCnt  = 0;
    ivCnt    = 0;
    roundCnt = 0;
    hashCnt  = 0;
    errCnt   = 0;
    start     = 1'b1;
    first_blk = fb;
    msg_valid = 1'b1;
    for (int c = 2; c <= 300; c++) begin
      nextCycle();
      if (!holdStart) start = 1'b0;
      inStall = (stallLen > 0) && (c >= stallAt + 3) && (c < stallAt + 3 + stallLen);
      if (inStall) msg_valid = 1'b0;
      else if (toggle && c >= 19) msg_valid = c[0];
      else msg_valid = 1'b1;
      #1;
      if ((int'(init_en) + int'(round_en) + int'(hash_upd_en) + int'(done)) > 1) errCnt++;
      if (init_en) begin
        initCnt++;
        if (init_iv) ivCnt++;
      end
      if (round_en) begin
        if (round_idx !== 7'(expIdx)) errCnt++;
        if (expIdx < 16 && (w_sel !== 1'b0 || msg_ready !== 1'b1)) errCnt++;
        if (expIdx >= 16 && (w_sel !== 1'b1 || msg_ready !== 1'b0 || sched_en !== 1'b1)) errCnt++;
        expIdx++;
        roundCnt++;
      end
      if (inStall && (round_en !== 1'b0 || sched_en !== 1'b0 || msg_ready !== 1'b0 ||
                      round_idx !== 7'(stallAt))) errCnt++;
      if (toggle && c >= 19 && c <= 82 && round_en !== 1'b1) errCnt++;
      if (hash_upd_en) hashCnt++;
      if (done) begin
        doneCyc = c;
        break;
      end
    end
  endtask

  initial begin
    int dc, ic, ivc, rc, hc, ec, waitCyc;
    RST       = 1'b1;
    start     = 1'b0;
    first_blk = 1'b0;
    msg_valid = 1'b0;

    nextCycle();
    nextCycle();
    checkOutput("reset_outputs", 32'(outs), 32'd0);
    start = 1'b1;
    nextCycle();
    checkOutput("reset_ignores_start", 32'(busy), 32'd0);

    // Full first block straight out of reset, no stalls.
    RST = 1'b0;
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, dc, ic, ivc, rc, hc, ec);
    checkOutput("blk1_done_cycle", 32'(dc), 32'd84);
    checkOutput("blk1_init_cnt", 32'(ic), 32'd1);
    checkOutput("blk1_iv_cnt", 32'(ivc), 32'd1);
    checkOutput("blk1_round_cnt", 32'(rc), 32'd80);
    checkOutput("blk1_hash_cnt", 32'(hc), 32'd1);
    checkOutput("blk1_seq_errs", 32'(ec), 32'd0);
    nextCycle();
    checkOutput("blk1_idle_after", 32'(outs), 32'd0);

    // Three stall cycles at round 5.
    applyStimulus(1'b0, 5, 3, 1'b0, 1'b0, dc, ic, ivc, rc, hc, ec);
    checkOutput("stall_done_cycle", 32'(dc), 32'd87);
    checkOutput("stall_iv_cnt", 32'(ivc), 32'd0);
    checkOutput("stall_round_cnt", 32'(rc), 32'd80);
    checkOutput("stall_seq_errs", 32'(ec), 32'd0);
    nextCycle();

    // msg_valid toggling once the schedule takes over.
    applyStimulus(1'b1, 0, 0, 1'b1, 1'b0, dc, ic, ivc, rc, hc, ec);
    checkOutput("toggle_done_cycle", 32'(dc), 32'd84);
    checkOutput("toggle_round_cnt", 32'(rc), 32'd80);
    checkOutput("toggle_seq_errs", 32'(ec), 32'd0);
    nextCycle();

    // start held high through a whole block, then a chained second block.
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b1, dc, ic, ivc, rc, hc, ec);
    checkOutput("hold_done_cycle", 32'(dc), 32'd84);
    checkOutput("hold_seq_errs", 32'(ec), 32'd0);
    nextCycle();
    first_blk = 1'b0;
    #1;
    checkOutput("hold_idle_busy", 32'(busy), 32'd0);
    nextCycle();
    checkOutput("hold_blk2_init_en", 32'(init_en), 32'd1);
    checkOutput("hold_blk2_init_iv", 32'(init_iv), 32'd0);
    start   = 1'b0;
    waitCyc = -1;
    for (int i = 1; i <= 200; i++) begin
      nextCycle();
      if (done) begin
        waitCyc = i;
        break;
      end
    end
    checkOutput("hold_blk2_done_wait", 32'(waitCyc), 32'd82);
    nextCycle();

    // Asynchronous reset in the middle of ROUND.
    start     = 1'b1;
    first_blk = 1'b1;
    msg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      nextCycle();
      start = 1'b0;
      #1;
      if (round_idx == 7'd40) break;
    end
    checkOutput("rst_reached_40", 32'(round_idx), 32'd40);
    RST = 1'b1;
    #1;
    checkOutput("rst_mid_round_outs", 32'(outs), 32'd0);
    nextCycle();
    RST = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, dc, ic, ivc, rc, hc, ec);
    checkOutput("rst_rerun_done_cycle", 32'(dc), 32'd84);
    checkOutput("rst_rerun_iv_cnt", 32'(ivc), 32'd0);
    checkOutput("rst_rerun_round_cnt", 32'(rc), 32'd80);
    checkOutput("rst_rerun_seq_errs", 32'(ec), 32'd0);
    nextCycle();

`ifdef SHA_CTRL_ABORT_EN
    // Abort at round 70 must drop the block without hashing or done.
    start     = 1'b1;
    first_blk = 1'b1;
    msg_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      nextCycle();
      start = 1'b0;
      #1;
      if (round_idx == 7'd70) break;
    end
    checkOutput("abort_reached_70", 32'(round_idx), 32'd70);
    abort = 1'b1;
    #1;
    checkOutput("abort_round_en", 32'(round_en), 32'd0);
    nextCycle();
    abort = 1'b0;
    #1;
    checkOutput("abort_idle_outs", 32'(outs), 32'd0);
    hc = 0;
    for (int i = 0; i < 15; i++) begin
      nextCycle();
      if (hash_upd_en || done || busy) hc++;
    end
    checkOutput("abort_no_finish", 32'(hc), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
